// File: rtl/hwpe_stream_tcdm_responder.sv
// hwpe_stream_tcdm_responder
//
// Single-port TCDM slave model. It is backed by a small flop memory and
// answers every accepted request one cycle later. Responses cannot be
// back-pressured, so one response register is all the buffering it needs.
//
// Parameters
//   STEP       data width in bytes (DW = 8*STEP); also the byte-enable width
//   NB_WORDS   memory depth in STEP-byte words
//   BASE_ADDR  byte address of word 0
//
// Ports
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   clear_i         synchronous soft clear. Resets the response, the error
//                   flag, the counters and the LFSR, and keeps the memory.
//   enable_i        grant enable
//   tcdm_req_i      request valid
//   tcdm_gnt_o      request grant (combinational)
//   tcdm_add_i      byte address
//   tcdm_wen_i      1 = read, 0 = write
//   tcdm_be_i       byte enables (writes only)
//   tcdm_data_i     write data
//   tcdm_r_data_o   response data, registered, held while r_valid is low
//   tcdm_r_valid_o  response valid, one cycle after each acceptance
//   err_o           sticky out-of-range flag
//   nb_reads_o      saturating count of granted reads
//   nb_writes_o     saturating count of granted writes
//
// Build option
//   HWPE_STREAM_TCDM_RESPONDER_STALL_EN  when defined, an 8-bit Fibonacci
//   LFSR (taps 8,6,5,4; seed 8'hA5) withholds the grant in every cycle
//   where lfsr[0] = 1.

module hwpe_stream_tcdm_responder #(
  parameter int unsigned STEP      = 4,
  parameter int unsigned NB_WORDS  = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic                tcdm_req_i,
  output logic                tcdm_gnt_o,
  input  logic [31:0]         tcdm_add_i,
  input  logic                tcdm_wen_i,
  input  logic [STEP-1:0]     tcdm_be_i,
  input  logic [8*STEP-1:0]   tcdm_data_i,
  output logic [8*STEP-1:0]   tcdm_r_data_o,
  output logic                tcdm_r_valid_o,
  output logic                err_o,
  output logic [15:0]         nb_reads_o,
  output logic [15:0]         nb_writes_o
);

  localparam int unsigned DW   = 8 * STEP;
  localparam int unsigned OFFW = $clog2(STEP);
  localparam int unsigned IDXW = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  logic [31:0]     off;
  logic [31:0]     idx32;
  logic [IDXW-1:0] idx;
  logic            in_range;
  logic            stall;
  logic            accept;

  logic [DW-1:0] mem_q [NB_WORDS];
  logic [DW-1:0] mem_d [NB_WORDS];
  logic          r_valid_q, r_valid_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic          err_q, err_d;
  logic [15:0]   nb_reads_q, nb_reads_d;
  logic [15:0]   nb_writes_q, nb_writes_d;

  // The subtraction wraps for addresses below BASE_ADDR. The explicit >=
  // test catches those cases, because the wrapped index can still look
  // small when NB_WORDS is large.
  assign off      = tcdm_add_i - BASE_ADDR;
  assign idx32    = off >> OFFW;
  assign idx      = idx32[IDXW-1:0];
  assign in_range = (tcdm_add_i >= BASE_ADDR) && (idx32 < NB_WORDS);

`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (clear_i) lfsr_d = 8'hA5;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // A clear wins over a request in the same cycle, so no grant is given then.
  assign tcdm_gnt_o = tcdm_req_i & enable_i & ~stall & ~clear_i;
  assign accept     = tcdm_gnt_o;

  always_comb begin
    mem_d       = mem_q;
    r_valid_d   = accept;
    r_data_d    = r_data_q;
    err_d       = err_q;
    nb_reads_d  = nb_reads_q;
    nb_writes_d = nb_writes_q;
    if (clear_i) begin
      r_valid_d   = 1'b0;
      r_data_d    = '0;
      err_d       = 1'b0;
      nb_reads_d  = '0;
      nb_writes_d = '0;
    end else if (accept) begin
      // The response carries the word as it was before this cycle's write.
      r_data_d = in_range ? mem_q[idx] : '0;
      if (!in_range) err_d = 1'b1;
      if (tcdm_wen_i) begin
        if (nb_reads_q != 16'hFFFF) nb_reads_d = nb_reads_q + 16'd1;
      end else begin
        if (nb_writes_q != 16'hFFFF) nb_writes_d = nb_writes_q + 16'd1;
        if (in_range) begin
          for (int b = 0; b < STEP; b++) begin
            if (tcdm_be_i[b]) mem_d[idx][8*b +: 8] = tcdm_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q       <= '{default: '0};
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      err_q       <= 1'b0;
      nb_reads_q  <= '0;
      nb_writes_q <= '0;
    end else begin
      mem_q       <= mem_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      err_q       <= err_d;
      nb_reads_q  <= nb_reads_d;
      nb_writes_q <= nb_writes_d;
    end
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign err_o          = err_q;
  assign nb_reads_o     = nb_reads_q;
  assign nb_writes_o    = nb_writes_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Testbench for hwpe_stream_tcdm_responder. A word-array reference model is
// compared with the DUT on every falling edge. Directed transactions pin the
// model with hand-computed literals, and a randomized phase follows them.
// The bench honours HWPE_STREAM_TCDM_RESPONDER_STALL_EN in the same way as
// the design.

module tb_hwpe_stream_tcdm_responder;

  localparam int unsigned STEP = 4;
  localparam int unsigned NB   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        en = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] add = '0;
  logic        wen = 1'b1;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] r_data;
  logic        r_valid;
  logic        err;
  logic [15:0] nb_reads, nb_writes;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  hwpe_stream_tcdm_responder #(.STEP(STEP), .NB_WORDS(NB), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(en),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(r_data),
    .tcdm_r_valid_o(r_valid), .err_o(err), .nb_reads_o(nb_reads),
    .nb_writes_o(nb_writes)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [NB];
  logic        m_rv;
  logic [31:0] m_rd;
  logic        m_err;
  logic [15:0] m_nr, m_nw;
  logic [7:0]  m_lfsr;

  function automatic logic [31:0] widx(input logic [31:0] a);
    return (a - BASE) / 32'(STEP);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (widx(a) < 32'(NB));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic logic m_stall();
`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
    return m_lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_gnt();
    return req & en & ~clear & ~m_stall();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rv <= 1'b0; m_rd <= '0; m_err <= 1'b0; m_nr <= '0; m_nw <= '0;
      m_lfsr <= 8'hA5;
      for (int i = 0; i < NB; i++) m_mem[i] <= '0;
    end else begin
      m_lfsr <= clear ? 8'hA5 : lfsr_next(m_lfsr);
      if (clear) begin
        m_rv <= 1'b0; m_rd <= '0; m_err <= 1'b0; m_nr <= '0; m_nw <= '0;
      end else begin
        m_rv <= exp_gnt();
        if (exp_gnt()) begin
          m_rd <= in_rng(add) ? m_mem[widx(add)] : 32'h0;
          if (!in_rng(add)) m_err <= 1'b1;
          if (wen) m_nr <= (m_nr == 16'hFFFF) ? m_nr : m_nr + 16'd1;
          else     m_nw <= (m_nw == 16'hFFFF) ? m_nw : m_nw + 16'd1;
          if (!wen && in_rng(add)) m_mem[widx(add)] <= merge(m_mem[widx(add)], wdata, be);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("gnt", {31'd0, gnt}, {31'd0, exp_gnt()});
        chk("r_valid", {31'd0, r_valid}, {31'd0, m_rv});
        chk("r_data", r_data, m_rd);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("nb_reads", {16'd0, nb_reads}, {16'd0, m_nr});
        chk("nb_writes", {16'd0, nb_writes}, {16'd0, m_nw});
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output logic rv);
    int n;
    @(posedge clk); #1;
    req = 1'b1; add = a; wen = w; be = b; wdata = d;
    n = 0;
    @(negedge clk);
    while (!gnt && n < 64) begin n++; @(negedge clk); end
    chk("gnt_wait", {31'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rd = r_data; rv = r_valid;
  endtask

  logic [31:0] rd;
  logic        rv;
  int          cyc, grants, wait_cnt;
  bit          last_gnt;

  initial begin
    #3 rst_n = 1'b0;
    #20;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_nb_reads", {16'd0, nb_reads}, 32'd0);

    // Write then read.
    xact(BASE + 8, 1'b0, 4'hF, 32'hCAFEBABE, rd, rv);
    chk("wr_rvalid", {31'd0, rv}, 32'd1);
    xact(BASE + 8, 1'b1, 4'h0, 32'h0, rd, rv);
    chk("rd_rvalid", {31'd0, rv}, 32'd1);
    chk("rd_cafebabe", rd, 32'hCAFEBABE);

    // Partial write.
    xact(BASE + 12, 1'b0, 4'hF, 32'h11223344, rd, rv);
    xact(BASE + 12, 1'b0, 4'b0101, 32'hAABBCCDD, rd, rv);
    xact(BASE + 12, 1'b1, 4'h0, 32'h0, rd, rv);
    chk("partial_wr", rd, 32'h11BB33DD);

    // Read-before-write.
    xact(BASE + 16, 1'b0, 4'hF, 32'h5, rd, rv);
    xact(BASE + 16, 1'b0, 4'hF, 32'h0, rd, rv);
    chk("rbw_old", rd, 32'h5);
    xact(BASE + 16, 1'b1, 4'h0, 32'h0, rd, rv);
    chk("rbw_new", rd, 32'h0);

    // Last word is in range.
    xact(BASE + 4*(NB-1), 1'b0, 4'hF, 32'hDEADBEEF, rd, rv);
    xact(BASE + 4*(NB-1), 1'b1, 4'h0, 32'h0, rd, rv);
    chk("last_word", rd, 32'hDEADBEEF);
    chk("last_word_err", {31'd0, err}, 32'd0);

    // Out of range: one past the end.
    xact(BASE + 4*NB, 1'b1, 4'h0, 32'h0, rd, rv);
    chk("oor_rvalid", {31'd0, rv}, 32'd1);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_nb_reads", {16'd0, nb_reads}, 32'd5);
    chk("oor_nb_writes", {16'd0, nb_writes}, 32'd6);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // A clear wins over a simultaneous write. The memory is kept.
    @(posedge clk); #1;
    clear = 1'b1; req = 1'b1; wen = 1'b0; add = BASE + 8; be = 4'hF; wdata = 32'h0;
    @(negedge clk);
    chk("clear_gnt", {31'd0, gnt}, 32'd0);
    @(posedge clk); #1 clear = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("clear_err", {31'd0, err}, 32'd0);
    chk("clear_nb_reads", {16'd0, nb_reads}, 32'd0);
    xact(BASE + 8, 1'b1, 4'h0, 32'h0, rd, rv);
    chk("mem_retained", rd, 32'hCAFEBABE);

    // Below base: out of range.
    xact(BASE - 4, 1'b0, 4'hF, 32'h12345678, rd, rv);
    chk("below_base_err", {31'd0, err}, 32'd1);
    chk("below_base_rdata", rd, 32'h0);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;

    // Flow control: disabled enable.
    en = 1'b0; req = 1'b1; wen = 1'b1; add = BASE;
    repeat (5) @(negedge clk);
    chk("dis_gnt", {31'd0, gnt}, 32'd0);
    chk("dis_nb_reads", {16'd0, nb_reads}, 32'd0);
    chk("dis_rvalid", {31'd0, r_valid}, 32'd0);

    // Back-to-back reads.
    @(posedge clk); #1 en = 1'b1;
    grants = 0; cyc = 0;
    while (grants < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gnt) grants++;
      if (grants == 10) begin
        @(posedge clk); #1 req = 1'b0;
      end else begin
        @(posedge clk); #1 add = BASE + 4*32'($urandom_range(0, NB-1));
      end
    end
    @(negedge clk);
    chk("b2b_grants", grants, 32'd10);
`ifndef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
    chk("b2b_cycles", cyc, 32'd10);
`endif
    chk("b2b_nb_reads", {16'd0, nb_reads}, 32'd10);

    // Randomized traffic. A request is held until it is granted.
    last_gnt = 1'b0; wait_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!req || last_gnt) begin
        wait_cnt = 0;
        req   = ($urandom_range(0, 3) != 0);
        wen   = $urandom_range(0, 1) == 1;
        be    = 4'($urandom_range(0, 15));
        wdata = $urandom();
        add   = BASE + 4*32'($urandom_range(0, NB + 3)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) add = BASE - 32'($urandom_range(1, 64));
      end else begin
        wait_cnt++;
      end
      en    = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      last_gnt = gnt;
      if (wait_cnt > 64) begin
        chk("rand_starved", 32'(wait_cnt), 32'd0);
        wait_cnt = 0;
      end
    end
    @(posedge clk); #1 req = 1'b0; clear = 1'b0; en = 1'b1;

    // A reset in the middle of operation drops the pending response.
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b1; add = BASE + 8;
    cyc = 0;
    @(negedge clk);
    while (!gnt && cyc < 64) begin cyc++; @(negedge clk); end
    chk("rst_mid_gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; req = 1'b0;
    #1;
    chk("rst_mid_rvalid", {31'd0, r_valid}, 32'd0);
    chk("rst_mid_rdata", r_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xact(BASE + 8, 1'b1, 4'h0, 32'h0, rd, rv);
    chk("rst_mem_cleared", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
